// File: rtl/cam_pixel_capture.sv
// OV7670 pixel front-end: pairs camera bytes into RGB565 words for the input FIFO,
// frames the stream on VSYNC/HREF, checks geometry and drops frames on FIFO overflow.
module cam_pixel_capture #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned HI_WM    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  data_cam,
  input  logic        VSYNC_cam,
  input  logic        HREF_cam,
  input  logic [9:0]  fifo_wrusedw,
  input  logic        fifo_full,
  output logic        wr_fifo,
  output logic [15:0] fifo_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] H_MAX = 12'(H_PIXELS);
  localparam logic [9:0]  V_MAX = 10'(V_LINES);
  localparam logic [9:0]  WM    = 10'(HI_WM);

  typedef enum logic [2:0] {IDLE, SYNC, GAP, ACT, DROP} state_t;
  state_t state, state_nx;

  logic [7:0]  d_r, hi_byte;
  logic        href_r, href_q, vs_r, vs_q;
  logic        byte_ph, started, err_flag;
  logic [11:0] pix_cnt;
  logic [9:0]  line_cnt;

  logic vs_rise, vs_fall, href_rise, href_fall;
  logic word_cyc, in_range, ovf;
  logic wr_nx, start_nx, done_nx, err_nx, err_set, clr_frame;

  assign vs_rise   = vs_r & ~vs_q;
  assign vs_fall   = ~vs_r & vs_q;
  assign href_rise = href_r & ~href_q;
  assign href_fall = ~href_r & href_q;

  // A word completing on the VSYNC rise cycle belongs to a truncated line and is discarded.
  assign word_cyc = (state == ACT) && href_r && byte_ph && !vs_rise;
  assign in_range = (line_cnt < V_MAX) && (pix_cnt < H_MAX);
  assign ovf      = word_cyc && in_range && (fifo_full || (fifo_wrusedw >= WM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_nx     = 1'b0;
    start_nx  = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    err_set   = 1'b0;
    clr_frame = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nx = SYNC;
        SYNC: if (vs_rise) state_nx = GAP;
        GAP: begin
          if (vs_fall) begin
            state_nx  = ACT;
            clr_frame = 1'b1;
          end
        end
        ACT: begin
          if (ovf) begin
            state_nx = DROP;
            err_set  = 1'b1;
          end else if (vs_rise) begin
            state_nx = GAP;
            // HREF still high here means the last line was cut short.
            if (line_cnt == V_MAX && !err_flag && !href_r) done_nx = 1'b1;
            else                                            err_nx  = 1'b1;
          end else begin
            if (word_cyc) begin
              if (in_range) wr_nx   = 1'b1;
              else          err_set = 1'b1;
            end
            if (href_fall && (pix_cnt != H_MAX || byte_ph)) err_set = 1'b1;
            if (href_rise && !started) start_nx = 1'b1;
          end
        end
        DROP: begin
          if (vs_rise) begin
            state_nx = GAP;
            err_nx   = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r         <= '0;
      href_r      <= 1'b0;
      href_q      <= 1'b0;
      vs_r        <= 1'b0;
      vs_q        <= 1'b0;
      byte_ph     <= 1'b0;
      hi_byte     <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      err_flag    <= 1'b0;
      started     <= 1'b0;
      wr_fifo     <= 1'b0;
      fifo_data   <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      d_r    <= data_cam;
      href_r <= HREF_cam;
      vs_r   <= VSYNC_cam;
      href_q <= href_r;
      vs_q   <= vs_r;

      byte_ph <= href_r ? ~byte_ph : 1'b0;
      if (href_r && !byte_ph) hi_byte <= d_r;

      if (!href_r)                         pix_cnt <= '0;
      else if (word_cyc && pix_cnt != '1) pix_cnt <= pix_cnt + 12'd1;

      if (clr_frame)                                            line_cnt <= '0;
      else if (state == ACT && href_fall && line_cnt != '1)     line_cnt <= line_cnt + 10'd1;

      if (clr_frame)    err_flag <= 1'b0;
      else if (err_set) err_flag <= 1'b1;

      if (clr_frame)     started <= 1'b0;
      else if (start_nx) started <= 1'b1;

      wr_fifo     <= wr_nx;
      if (wr_nx) fifo_data <= {hi_byte, d_r};
      frame_start <= start_nx;
      frame_done  <= done_nx;
      frame_err   <= err_nx;
      if (done_nx) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture on a reduced 4-word x 3-line geometry.
module tb_cam_pixel_capture;
  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  data_cam = '0;
  logic        VSYNC_cam = 1'b0;
  logic        HREF_cam = 1'b0;
  logic [9:0]  fifo_wrusedw = '0;
  logic        fifo_full = 1'b0;
  logic        wr_fifo;
  logic [15:0] fifo_data;
  logic        frame_start, frame_done, frame_err;
  logic [15:0] frame_cnt;

  int vec = 0;
  int miss = 0;
  int n_wr = 0, n_start = 0, n_done = 0, n_err = 0;
  logic [15:0] words[$];

  cam_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .HI_WM(1000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_cam(data_cam),
    .VSYNC_cam(VSYNC_cam), .HREF_cam(HREF_cam), .fifo_wrusedw(fifo_wrusedw),
    .fifo_full(fifo_full), .wr_fifo(wr_fifo), .fifo_data(fifo_data),
    .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_fifo === 1'b1) begin
      n_wr++;
      words.push_back(fifo_data);
    end
    if (frame_start === 1'b1) n_start++;
    if (frame_done === 1'b1)  n_done++;
    if (frame_err === 1'b1)   n_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input logic vs, input logic href, input logic [7:0] d);
    VSYNC_cam = vs;
    HREF_cam  = href;
    data_cam  = d;
    @(posedge clk);
    #2;
  endtask

  task automatic send_line(input int nbytes, input int base);
    for (int i = 0; i < nbytes; i++) cyc(1'b0, 1'b1, 8'(base + i));
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int lines, input int base);
    for (int l = 0; l < lines; l++) send_line(2 * H, base + l * 16);
    vs_pulse();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    vec++; if ({wr_fifo, frame_start, frame_done, frame_err} !== 4'b0) begin
      miss++; $display("FAIL reset_pulses: got %b expected 0000", {wr_fifo, frame_start, frame_done, frame_err}); end
    vec++; if (fifo_data !== 16'h0000) begin
      miss++; $display("FAIL reset_data: got %h expected 0000", fifo_data); end
    vec++; if (frame_cnt !== 16'd0) begin
      miss++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
    vec++; if (dut.state !== 3'd0) begin
      miss++; $display("FAIL reset_state: got %0d expected 0 (IDLE)", dut.state); end
  endtask

  task automatic test_frames();
    int w0, s0, d0, e0, idx;
    logic [15:0] exp_w;
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    vs_pulse();
    w0 = n_wr; s0 = n_start; d0 = n_done; e0 = n_err;
    send_frame(V, 0);
    send_frame(V, 64);
    vec++; if (n_wr - w0 !== 2 * V * H) begin
      miss++; $display("FAIL frames_writes: got %0d expected %0d", n_wr - w0, 2 * V * H); end
    vec++; if (n_start - s0 !== 2) begin
      miss++; $display("FAIL frames_start: got %0d expected 2", n_start - s0); end
    vec++; if (n_done - d0 !== 2) begin
      miss++; $display("FAIL frames_done: got %0d expected 2", n_done - d0); end
    vec++; if (n_err - e0 !== 0) begin
      miss++; $display("FAIL frames_err: got %0d expected 0", n_err - e0); end
    vec++; if (frame_cnt !== 16'd2) begin
      miss++; $display("FAIL frames_cnt: got %0d expected 2", frame_cnt); end
    idx = w0;
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < V; l++)
        for (int j = 0; j < H; j++) begin
          exp_w = {8'(f * 64 + l * 16 + 2 * j), 8'(f * 64 + l * 16 + 2 * j + 1)};
          vec++;
          if (idx >= words.size()) begin
            miss++; $display("FAIL frames_data[%0d]: got none expected %h", idx - w0, exp_w);
          end else if (words[idx] !== exp_w) begin
            miss++; $display("FAIL frames_data[%0d]: got %h expected %h", idx - w0, words[idx], exp_w);
          end
          idx++;
        end
  endtask

  task automatic test_pairing();
    int d0;
    d0 = n_done;
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 8'h3C);
    #3;
    vec++; if (wr_fifo !== 1'b0) begin
      miss++; $display("FAIL pair_early: wr_fifo got %b expected 0", wr_fifo); end
    cyc(1'b0, 1'b1, 8'h11);
    #3;
    vec++; if (wr_fifo !== 1'b1) begin
      miss++; $display("FAIL pair_strobe: wr_fifo got %b expected 1", wr_fifo); end
    vec++; if (fifo_data !== 16'hA53C) begin
      miss++; $display("FAIL pair_data: got %h expected a53c", fifo_data); end
    cyc(1'b0, 1'b1, 8'h22);
    #3;
    vec++; if (wr_fifo !== 1'b0 || fifo_data !== 16'hA53C) begin
      miss++; $display("FAIL pair_hold: got wr=%b data=%h expected wr=0 data=a53c", wr_fifo, fifo_data); end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h33 + 8'(i * 16'h11)));
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    send_line(2 * H, 16);
    send_line(2 * H, 32);
    vs_pulse();
    vec++; if (n_done - d0 !== 1 || frame_cnt !== 16'd3) begin
      miss++; $display("FAIL pair_frame: got done=%0d cnt=%0d expected done=1 cnt=3", n_done - d0, frame_cnt); end
  endtask

  task automatic test_enable_mid();
    int w0, s0, d0, e0;
    rst_n = 1'b0;
    enable = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    w0 = n_wr; s0 = n_start; d0 = n_done; e0 = n_err;
    send_line(2 * H, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(i));
    enable = 1'b1;
    for (int i = 3; i < 2 * H; i++) cyc(1'b0, 1'b1, 8'(i));
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    send_line(2 * H, 32);
    vs_pulse();
    vec++; if (n_wr - w0 !== 0 || n_start - s0 !== 0 || n_done - d0 !== 0 || n_err - e0 !== 0) begin
      miss++; $display("FAIL enmid_partial: got wr=%0d st=%0d dn=%0d er=%0d expected all 0",
                       n_wr - w0, n_start - s0, n_done - d0, n_err - e0); end
    w0 = n_wr;
    send_frame(V, 0);
    vec++; if (n_wr - w0 !== V * H || n_done - d0 !== 1 || frame_cnt !== 16'd1) begin
      miss++; $display("FAIL enmid_next: got wr=%0d dn=%0d cnt=%0d expected wr=%0d dn=1 cnt=1",
                       n_wr - w0, n_done - d0, frame_cnt, V * H); end
  endtask

  task automatic test_overflow();
    int w0, d0, e0;
    logic [15:0] c0;
    c0 = frame_cnt;
    d0 = n_done; e0 = n_err;
    fifo_wrusedw = 10'd999;
    send_frame(V, 0);
    fifo_wrusedw = 10'd0;
    vec++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      miss++; $display("FAIL ovf_999: got dn=%0d er=%0d expected dn=1 er=0", n_done - d0, n_err - e0); end
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_line(2 * H, 0);
    fifo_wrusedw = 10'd1000;
    send_line(2 * H, 16);
    fifo_wrusedw = 10'd0;
    send_line(2 * H, 32);
    vs_pulse();
    vec++; if (n_wr - w0 !== H) begin
      miss++; $display("FAIL ovf_writes: got %0d expected %0d", n_wr - w0, H); end
    vec++; if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
      miss++; $display("FAIL ovf_pulse: got er=%0d dn=%0d expected er=1 dn=0", n_err - e0, n_done - d0); end
    w0 = n_wr; d0 = n_done;
    send_frame(V, 0);
    vec++; if (n_wr - w0 !== V * H || n_done - d0 !== 1) begin
      miss++; $display("FAIL ovf_recover: got wr=%0d dn=%0d expected wr=%0d dn=1", n_wr - w0, n_done - d0, V * H); end
    w0 = n_wr; e0 = n_err;
    send_line(2 * H, 0);
    send_line(2 * H, 16);
    fifo_full = 1'b1;
    send_line(2 * H, 32);
    fifo_full = 1'b0;
    vs_pulse();
    vec++; if (n_wr - w0 !== 2 * H || n_err - e0 !== 1) begin
      miss++; $display("FAIL ovf_full: got wr=%0d er=%0d expected wr=%0d er=1", n_wr - w0, n_err - e0, 2 * H); end
    vec++; if (frame_cnt !== c0 + 16'd2) begin
      miss++; $display("FAIL ovf_cnt: got %0d expected %0d", frame_cnt, c0 + 16'd2); end
  endtask

  task automatic test_geometry();
    int w0, d0, e0;
    logic [15:0] c0;
    c0 = frame_cnt;
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_line(2 * H - 1, 0);
    send_line(2 * H + 2, 16);
    send_line(2 * H, 32);
    vs_pulse();
    vec++; if (n_wr - w0 !== 3 * H - 1) begin
      miss++; $display("FAIL geom_writes: got %0d expected %0d", n_wr - w0, 3 * H - 1); end
    vec++; if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
      miss++; $display("FAIL geom_pulse: got er=%0d dn=%0d expected er=1 dn=0", n_err - e0, n_done - d0); end
    w0 = n_wr; e0 = n_err;
    send_frame(V + 1, 0);
    vec++; if (n_wr - w0 !== V * H || n_err - e0 !== 1) begin
      miss++; $display("FAIL geom_extra_line: got wr=%0d er=%0d expected wr=%0d er=1", n_wr - w0, n_err - e0, V * H); end
    vec++; if (frame_cnt !== c0) begin
      miss++; $display("FAIL geom_cnt: got %0d expected %0d", frame_cnt, c0); end
  endtask

  task automatic test_reset_mid();
    int w0, s0, d0, e0;
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_frame(V - 1, 0);
    vec++; if (n_wr - w0 !== (V - 1) * H || n_err - e0 !== 1 || n_done - d0 !== 0) begin
      miss++; $display("FAIL short_frame: got wr=%0d er=%0d dn=%0d expected wr=%0d er=1 dn=0",
                       n_wr - w0, n_err - e0, n_done - d0, (V - 1) * H); end
    send_line(2 * H, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(i));
    rst_n = 1'b0;
    #1;
    vec++; if ({wr_fifo, frame_start, frame_done, frame_err} !== 4'b0 || fifo_data !== 16'h0 || frame_cnt !== 16'h0) begin
      miss++; $display("FAIL rstmid_outputs: got wr=%b st=%b dn=%b er=%b data=%h cnt=%0d expected all 0",
                       wr_fifo, frame_start, frame_done, frame_err, fifo_data, frame_cnt); end
    vec++; if (dut.state !== 3'd0) begin
      miss++; $display("FAIL rstmid_state: got %0d expected 0 (IDLE)", dut.state); end
    cyc(1'b0, 1'b1, 8'h03);
    rst_n = 1'b1;
    w0 = n_wr; s0 = n_start; d0 = n_done; e0 = n_err;
    for (int i = 4; i < 2 * H; i++) cyc(1'b0, 1'b1, 8'(i));
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    send_line(2 * H, 16);
    vs_pulse();
    vec++; if (n_wr - w0 !== 0 || n_start - s0 !== 0 || n_done - d0 !== 0 || n_err - e0 !== 0) begin
      miss++; $display("FAIL rstmid_quiet: got wr=%0d st=%0d dn=%0d er=%0d expected all 0",
                       n_wr - w0, n_start - s0, n_done - d0, n_err - e0); end
    send_frame(V, 0);
    vec++; if (n_wr - w0 !== V * H || n_done - d0 !== 1 || frame_cnt !== 16'd1) begin
      miss++; $display("FAIL rstmid_recover: got wr=%0d dn=%0d cnt=%0d expected wr=%0d dn=1 cnt=1",
                       n_wr - w0, n_done - d0, frame_cnt, V * H); end
  endtask

  initial begin
    #2;
    test_reset();
    test_frames();
    test_pairing();
    test_enable_mid();
    test_overflow();
    test_geometry();
    test_reset_mid();
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
